// File: rtl/timetag_pkg.sv
// Shared types and constants for the timetag command path: opcodes, register
// bus widths and the command parser state encoding.
package timetag_pkg;

    localparam int REG_ADDR_W = 16;
    localparam int REG_DATA_W = 32;

    localparam logic [7:0] CMD_OP_READ  = 8'h72;
    localparam logic [7:0] CMD_OP_WRITE = 8'h77;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WR_EXEC,
        ST_RD_WAIT,
        ST_REPLY
    } parser_state_t;

endpackage

// File: rtl/cmd_parser_if.sv
// Command/reply byte channels and single-cycle register bus between the FX2
// interface, the command parser and the timetag register file.
interface cmd_parser_if;
    import timetag_pkg::*;

    logic [7:0]            cmd;
    logic                  cmd_wr;
    logic [7:0]            reply;
    logic                  reply_rdy;
    logic                  reply_ack;
    logic                  reply_end;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [REG_DATA_W-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [REG_DATA_W-1:0] reg_rdata;
    logic                  reg_rvalid;
    logic                  cmd_overrun;

    // Parser side
    modport master (
        input  cmd, cmd_wr, reply_ack, reg_rdata, reg_rvalid,
        output reply, reply_rdy, reply_end, reg_addr, reg_wdata,
        output reg_we, reg_re, cmd_overrun
    );

    // FX2 / register-file side
    modport slave (
        output cmd, cmd_wr, reply_ack, reg_rdata, reg_rvalid,
        input  reply, reply_rdy, reply_end, reg_addr, reg_wdata,
        input  reg_we, reg_re, cmd_overrun
    );

endinterface

// File: rtl/reply_shifter.sv
// Reply byte serializer: loads 1-4 bytes with a length, presents them LSB first,
// advances one byte per ack and flags the final byte of the frame.
module reply_shifter
    import timetag_pkg::*;
(
    input  logic                  fx2_clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [REG_DATA_W-1:0] load_data,
    input  logic [2:0]            load_len,
    input  logic                  reply_ack,
    output logic [7:0]            reply,
    output logic                  reply_rdy,
    output logic                  reply_end
);

    logic [REG_DATA_W-1:0] data_reg;
    logic [2:0]            left_reg;

    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            left_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
            left_reg <= load_len;
        end else if (reply_ack && left_reg != 3'd0) begin
            // Shifting in zeros leaves reply at 0 once the frame is drained
            data_reg <= {8'd0, data_reg[REG_DATA_W-1:8]};
            left_reg <= left_reg - 3'd1;
        end
    end

    assign reply     = data_reg[7:0];
    assign reply_rdy = (left_reg != 3'd0);
    assign reply_end = (left_reg == 3'd1);

endmodule

// File: rtl/cmd_parser.sv
// Host command parser: frames 0x72 reads and 0x77 writes into register bus
// transactions and returns read data. CMD_WRITE_ACK_EN adds a 0x77 write ack.
module cmd_parser
    import timetag_pkg::*;
#(
    parameter int RD_TIMEOUT = 255
) (
    input  logic         fx2_clk,
    input  logic         rst_n,
    cmd_parser_if.master bus
);

    localparam int               TMO_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT);

    parser_state_t         state_reg, state_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
    logic                  is_write_reg, is_write_next;
    logic                  overrun_reg, overrun_next;
    logic [REG_ADDR_W-1:0] addr_bus;
    logic [REG_DATA_W-1:0] wdata_bus;
    logic                  sh_load;
    logic [REG_DATA_W-1:0] sh_data;
    logic [2:0]            sh_len;

    // Byte lanes capture straight from the stream so they hold between frames
    for (genvar gi = 0; gi < REG_ADDR_W / 8; gi++) begin : g_addr_lane
        logic [7:0] lane_reg;
        always_ff @(posedge fx2_clk or negedge rst_n) begin
            if (!rst_n)
                lane_reg <= '0;
            else if (state_reg == ST_ADDR && bus.cmd_wr && byte_cnt_reg == 2'(gi))
                lane_reg <= bus.cmd;
        end
        assign addr_bus[gi*8 +: 8] = lane_reg;
    end

    for (genvar gi = 0; gi < REG_DATA_W / 8; gi++) begin : g_wdata_lane
        logic [7:0] lane_reg;
        always_ff @(posedge fx2_clk or negedge rst_n) begin
            if (!rst_n)
                lane_reg <= '0;
            else if (state_reg == ST_WDATA && bus.cmd_wr && byte_cnt_reg == 2'(gi))
                lane_reg <= bus.cmd;
        end
        assign wdata_bus[gi*8 +: 8] = lane_reg;
    end

    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            is_write_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            is_write_reg <= is_write_next;
            overrun_reg  <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        is_write_next = is_write_reg;
        overrun_next  = 1'b0;
        sh_load       = 1'b0;
        sh_data       = '0;
        sh_len        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_wr && (bus.cmd == CMD_OP_READ || bus.cmd == CMD_OP_WRITE)) begin
                    state_next    = ST_ADDR;
                    byte_cnt_next = '0;
                    is_write_next = (bus.cmd == CMD_OP_WRITE);
                end
            end
            ST_ADDR: begin
                if (bus.cmd_wr) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd1) begin
                        byte_cnt_next = '0;
                        tmo_cnt_next  = '0;
                        state_next    = is_write_reg ? ST_WDATA : ST_RD_WAIT;
                    end
                end
            end
            ST_WDATA: begin
                if (bus.cmd_wr) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3)
                        state_next = ST_WR_EXEC;
                end
            end
            ST_WR_EXEC: begin
                overrun_next = bus.cmd_wr;
`ifdef CMD_WRITE_ACK_EN
                sh_load    = 1'b1;
                sh_data    = {{(REG_DATA_W-8){1'b0}}, CMD_OP_WRITE};
                sh_len     = 3'd1;
                state_next = ST_REPLY;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_RD_WAIT: begin
                overrun_next = bus.cmd_wr;
                tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                // Count 0 is the reg_re cycle; rvalid is only honoured after it
                if (tmo_cnt_reg != '0 && bus.reg_rvalid) begin
                    sh_load    = 1'b1;
                    sh_data    = bus.reg_rdata;
                    sh_len     = 3'd4;
                    state_next = ST_REPLY;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    sh_load    = 1'b1;
                    sh_data    = '1;
                    sh_len     = 3'd4;
                    state_next = ST_REPLY;
                end
            end
            ST_REPLY: begin
                overrun_next = bus.cmd_wr;
                if (bus.reply_ack && bus.reply_end)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.reg_addr    = addr_bus;
    assign bus.reg_wdata   = wdata_bus;
    assign bus.reg_we      = (state_reg == ST_WR_EXEC);
    assign bus.reg_re      = (state_reg == ST_RD_WAIT) && (tmo_cnt_reg == '0);
    assign bus.cmd_overrun = overrun_reg;

    reply_shifter u_reply_shifter (
        .fx2_clk   (fx2_clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_data (sh_data),
        .load_len  (sh_len),
        .reply_ack (bus.reply_ack),
        .reply     (bus.reply),
        .reply_rdy (bus.reply_rdy),
        .reply_end (bus.reply_end)
    );

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser (RD_TIMEOUT = 8): reads, writes, timeout,
// reply backpressure, overrun, junk bytes and reset abort.
module tb_cmd_parser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmd_parser_if bus ();

    cmd_parser #(.RD_TIMEOUT(8)) dut (
        .fx2_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int re_count = 0;
    int we_count = 0;

    always @(negedge clk) begin
        if (bus.reg_re) re_count++;
        if (bus.reg_we) we_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.cmd    = b;
        bus.cmd_wr = 1'b1;
        step();
        bus.cmd_wr = 1'b0;
    endtask

    // Consume n bytes with reply_ack held high, one per cycle
    task automatic drain(input string tag, input logic [31:0] data, input int n);
        bus.reply_ack = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_rdy"}, 32'(bus.reply_rdy), 32'd1);
            chk({tag, "_byte"}, 32'(bus.reply), 32'(data[k*8 +: 8]));
            chk({tag, "_end"}, 32'(bus.reply_end), (k == n - 1) ? 32'd1 : 32'd0);
            step();
        end
        bus.reply_ack = 1'b0;
        chk({tag, "_done"}, 32'(bus.reply_rdy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reply"},   32'(bus.reply),       32'd0);
        chk({tag, "_rdy"},     32'(bus.reply_rdy),   32'd0);
        chk({tag, "_end"},     32'(bus.reply_end),   32'd0);
        chk({tag, "_addr"},    32'(bus.reg_addr),    32'd0);
        chk({tag, "_wdata"},   bus.reg_wdata,        32'd0);
        chk({tag, "_we"},      32'(bus.reg_we),      32'd0);
        chk({tag, "_re"},      32'(bus.reg_re),      32'd0);
        chk({tag, "_overrun"}, 32'(bus.cmd_overrun), 32'd0);
    endtask

    initial begin
        int n;
        int rc;
        int wc;
        int rdy_seen;

        rst_n          = 1'b0;
        bus.cmd        = 8'h00;
        bus.cmd_wr     = 1'b0;
        bus.reply_ack  = 1'b0;
        bus.reg_rdata  = 32'h0;
        bus.reg_rvalid = 1'b0;
        step(); step(); step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Read 0x0010, data returned in the first sampled cycle
        send(8'h72); send(8'h10); send(8'h00);
        chk("rd_re", 32'(bus.reg_re), 32'd1);
        chk("rd_addr", 32'(bus.reg_addr), 32'h0010);
        step();
        chk("rd_re_once", 32'(bus.reg_re), 32'd0);
        chk("rd_rdy_early", 32'(bus.reply_rdy), 32'd0);
        bus.reg_rdata  = 32'hA1B2C3D4;
        bus.reg_rvalid = 1'b1;
        step();
        bus.reg_rvalid = 1'b0;
        bus.reg_rdata  = 32'h0;
        drain("rd", 32'hA1B2C3D4, 4);
        chk("rd_re_count", 32'(re_count), 32'd1);

        // Write 0x12345678 to 0x0004
        send(8'h77); send(8'h04); send(8'h00);
        chk("wr_no_re", 32'(bus.reg_re), 32'd0);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("wr_we", 32'(bus.reg_we), 32'd1);
        chk("wr_addr", 32'(bus.reg_addr), 32'h0004);
        chk("wr_wdata", bus.reg_wdata, 32'h12345678);
        step();
        chk("wr_we_once", 32'(bus.reg_we), 32'd0);
        chk("wr_we_count", 32'(we_count), 32'd1);
`ifdef CMD_WRITE_ACK_EN
        drain("wack", 32'h00000077, 1);
`else
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.reply_rdy) rdy_seen++;
            step();
        end
        chk("wr_no_reply", 32'(rdy_seen), 32'd0);
`endif

        // Timeout: no rvalid, reply_rdy rises RD_TIMEOUT+1 cycles after reg_re
        send(8'h72); send(8'h20); send(8'h00);
        chk("tmo_re", 32'(bus.reg_re), 32'd1);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.reply_rdy) begin
                n = i;
                break;
            end
        end
        chk("tmo_latency", 32'(n), 32'd9);
        drain("tmo", 32'hFFFFFFFF, 4);

        // Next frame starts in the cycle right after the last ack
        send(8'h72); send(8'h30); send(8'h00);
        chk("b2b_re", 32'(bus.reg_re), 32'd1);
        chk("b2b_addr", 32'(bus.reg_addr), 32'h0030);
        step();
        bus.reg_rdata  = 32'h11223344;
        bus.reg_rvalid = 1'b1;
        step();
        bus.reg_rvalid = 1'b0;
        bus.reg_rdata  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold", {23'd0, bus.reply_rdy, bus.reply}, {23'd0, 1'b1, 8'h44});
        end
        rc = re_count;
        send(8'h72);
        chk("ovr_pulse", 32'(bus.cmd_overrun), 32'd1);
        chk("ovr_reply", 32'(bus.reply), 32'h44);
        step();
        chk("ovr_once", 32'(bus.cmd_overrun), 32'd0);
        drain("bp", 32'h11223344, 4);
        chk("ovr_no_read", 32'(re_count), 32'(rc));

        // Junk bytes are discarded in IDLE
        send(8'h00); send(8'hFF); send(8'h72); send(8'h01); send(8'h00);
        chk("junk_re", 32'(bus.reg_re), 32'd1);
        chk("junk_addr", 32'(bus.reg_addr), 32'h0001);
        chk("junk_count", 32'(re_count), 32'(rc + 1));
        step();
        bus.reg_rdata  = 32'hCAFE0001;
        bus.reg_rvalid = 1'b1;
        step();
        bus.reg_rvalid = 1'b0;
        drain("junk", 32'hCAFE0001, 4);

        // Reset mid-frame aborts the write
        wc = we_count;
        send(8'h77); send(8'h02);
        rst_n = 1'b0;
        step();
        chk_all_zero("abort");
        rst_n = 1'b1;
        step(); step();
        chk("abort_no_we", 32'(we_count), 32'(wc));
        send(8'h77); send(8'h05); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("post_we", 32'(bus.reg_we), 32'd1);
        chk("post_addr", 32'(bus.reg_addr), 32'h0005);
        chk("post_wdata", bus.reg_wdata, 32'hDEADBEEF);
        step();
        chk("post_we_count", 32'(we_count), 32'(wc + 1));
`ifdef CMD_WRITE_ACK_EN
        drain("post_wack", 32'h00000077, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
